// File: rtl/key_pkg.sv
// Shared definitions for the key filter: FSM encoding and default filter timing.
// Default CNT_MAX gives a 20 ms stability window at 50 MHz sys_clk with a /5 sample tick.
// No logic; imported by the interface, top and bench.
package key_pkg;

    // 50 MHz / 5 = 10 MHz tick; 20 ms = 200000 ticks, counted 0..199999.
    localparam int CNT_MAX_DEF = 199999;
    localparam int CNT_W_DEF   = 18;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } key_fsm_e;

endpackage

// File: rtl/key_filter_tick_if.sv
// Key filter bus: sample tick and raw key in, debounced level and press pulse out.
// master = upstream driver / consumer of the results; slave = key_filter_tick.
// Optional rel_flag (release pulse) present only when KEY_RELEASE_FLAG_EN is defined.
interface key_filter_tick_if;
    logic clk_flag;   // one-cycle sample tick from the /5 divider
    logic key_in;     // raw active-low button, asynchronous
    logic key_state;  // debounced level, 1 = released
    logic key_flag;   // one-cycle pulse per accepted press
`ifdef KEY_RELEASE_FLAG_EN
    logic rel_flag;   // one-cycle pulse per accepted release

    modport master (output clk_flag, output key_in,
                    input  key_state, input key_flag, input rel_flag);
    modport slave  (input  clk_flag, input key_in,
                    output key_state, output key_flag, output rel_flag);
`else
    modport master (output clk_flag, output key_in,
                    input  key_state, input key_flag);
    modport slave  (input  clk_flag, input key_in,
                    output key_state, output key_flag);
`endif
endinterface

// File: rtl/key_filter_tick_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; RST_VAL sets the reset level.
// Latency: 2 clk_i cycles. No backpressure; samples every cycle.
// Ports: clk_i, rst_n_i (async active-low), d_i (async in), q_o (synchronized out).
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_filter_tick.sv
// Key debouncer: 2-FF sync then FSM accepting a level only after CNT_MAX+1 stable clk_flag ticks.
// Latency: 2 sync cycles + 1 entry cycle + CNT_MAX+1 ticks; outputs registered.
// No backpressure: key_flag (and rel_flag with KEY_RELEASE_FLAG_EN) are single-cycle pulses.
// Ports: sys_clk, sys_rst_n (async active-low), bus (key_filter_tick_if.slave).
module key_filter_tick
    import key_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    key_filter_tick_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

    logic             key_s;
    key_fsm_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_state_q, key_state_d;
    logic             key_flag_q, key_flag_d;
`ifdef KEY_RELEASE_FLAG_EN
    logic             rel_flag_q, rel_flag_d;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk_i   (sys_clk),
        .rst_n_i (sys_rst_n),
        .d_i     (bus.key_in),
        .q_o     (key_s)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_state_q <= 1'b1;
            key_flag_q  <= 1'b0;
`ifdef KEY_RELEASE_FLAG_EN
            rel_flag_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            key_flag_q  <= key_flag_d;
`ifdef KEY_RELEASE_FLAG_EN
            rel_flag_q  <= rel_flag_d;
`endif
        end
    end

    // A level change on key_s always wins over a coincident tick, so a bounce
    // on the final tick still aborts the filter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        key_flag_d  = 1'b0;
`ifdef KEY_RELEASE_FLAG_EN
        rel_flag_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d = PRESS_FILT;
                    cnt_d   = '0;
                end
            end
            PRESS_FILT: begin
                if (key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.clk_flag) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d     = DOWN;
                        cnt_d       = '0;
                        key_state_d = 1'b0;
                        key_flag_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DOWN: begin
                if (key_s) begin
                    state_d = REL_FILT;
                    cnt_d   = '0;
                end
            end
            REL_FILT: begin
                if (!key_s) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (bus.clk_flag) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        key_state_d = 1'b1;
`ifdef KEY_RELEASE_FLAG_EN
                        rel_flag_d  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                key_state_d = 1'b1;
            end
        endcase
    end

    assign bus.key_state = key_state_q;
    assign bus.key_flag  = key_flag_q;
`ifdef KEY_RELEASE_FLAG_EN
    assign bus.rel_flag  = rel_flag_q;
`endif

endmodule

// File: doc/key_filter_tick.md
Name: key_filter_tick

Overview:
- Key debouncer downstream of the divide-by-5 tick generator.
- Uses the tick generator's one-cycle `clk_flag` pulse (one per 5 `sys_clk` cycles) as its sample enable.
- Filters a raw mechanical push-button with an FSM plus a tick-paced stability counter.
- Emits a debounced level and a one-cycle press pulse to downstream control logic (LED/mode toggles).

Parameters:
- `CNT_MAX`, default 199999: tick count minus 1 a level must be stable to be accepted (20 ms at 50 MHz with a /5 tick).
- `CNT_W`, default 18: width of the stability counter; must hold `CNT_MAX`.

Ports:
- `sys_clk`  input  1: system clock; all logic on its rising edge.
- `sys_rst_n`  input  1: asynchronous, active-low reset.
- `clk_flag`  input  1: sample-enable tick, one `sys_clk` cycle wide, from the /5 divider.
- `key_in`  input  1: raw button, active-low, asynchronous to `sys_clk`, bouncy.
- `key_state`  output  1: debounced level; 1 = released, 0 = pressed.
- `key_flag`  output  1: one `sys_clk` pulse on each accepted press.

Behaviour:
- Reset is asynchronous on `sys_rst_n` low; all state returns to defaults immediately, including mid-filter:
  - FSM = `IDLE`, `cnt` = 0, `key_state` = 1, `key_flag` = 0.
  - Both synchronizer stages reset to 1 (released).
- Synchronizer: 2-FF on `key_in`, giving `key_s`. Adds 2 `sys_clk` cycles of latency. Runs every cycle, not gated by the tick.
- FSM states: `IDLE`, `PRESS_FILT`, `DOWN`, `REL_FILT`; all outputs registered.
- `IDLE`: `key_s` == 0 → go to `PRESS_FILT`, `cnt` <= 0.
- `PRESS_FILT`:
  - `key_s` == 1 (bounce) → go to `IDLE`, `cnt` <= 0. Bounce takes priority over a simultaneous tick.
  - Else on `clk_flag` with `cnt` == `CNT_MAX` → go to `DOWN`, `key_state` <= 0, `key_flag` <= 1 for exactly one cycle.
  - Else on `clk_flag` → `cnt` <= `cnt` + 1.
  - No tick → hold.
- `DOWN`: `key_s` == 1 → go to `REL_FILT`, `cnt` <= 0.
- `REL_FILT`:
  - `key_s` == 0 → go to `DOWN`, `cnt` <= 0.
  - Else on `clk_flag` with `cnt` == `CNT_MAX` → go to `IDLE`, `key_state` <= 1.
  - Else on `clk_flag` → `cnt` <= `cnt` + 1.
- `key_flag` is 0 in every cycle other than the entry into `DOWN`; it never stays high across two cycles.
- Acceptance requires `CNT_MAX`+1 consecutive ticks of stable `key_s`. Total press latency from `key_s` falling is `CNT_MAX`+1 ticks, plus partial-tick phase, plus 0 registered cycles: `key_flag` is high in the first cycle `state` == `DOWN`.
- `cnt` never wraps: it is cleared on every state change and saturates logically at `CNT_MAX`.
- A `clk_flag` held high continuously is treated as a tick every cycle; legal, and used for fast simulation.
- Unused FSM encodings recover to `IDLE` with `key_state` = 1.

Optional Feature:
- Macro `KEY_RELEASE_FLAG_EN`.
- Defined:
  - Adds output port `rel_flag` (1 bit).
  - `rel_flag` is a one-cycle pulse in the first cycle `state` == `IDLE` after a confirmed release from `REL_FILT`.
  - Its reset value is 0.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `key_pkg`:
  - FSM state typedef/localparams `IDLE`=2'd0, `PRESS_FILT`=2'd1, `DOWN`=2'd2, `REL_FILT`=2'd3.
  - Default `CNT_MAX` for a 50 MHz `sys_clk` with the /5 tick.
- One natural sub-module: `sync_2ff` (parameterised reset value), reused for other async inputs.
- FSM and counter stay in `key_filter_tick`.

Test Plan (`CNT_MAX`=3, `clk_flag` every 5th cycle):
- Reset then idle, `key_in`=1 for 100 cycles → `key_state`=1, `key_flag` never asserted.
- `key_in` falls and is held 40 cycles → exactly one `key_flag` pulse after 4 ticks following `key_s` fall; `key_state`=0 from that cycle.
- `key_in` pulses low for 2 ticks, high 1 tick, repeated 5 times → no `key_flag`, `key_state` stays 1, FSM alternates `IDLE`/`PRESS_FILT`.
- `key_s` returns to 1 on the same cycle as a tick with `cnt`=3 in `PRESS_FILT` → bounce wins: `IDLE`, no `key_flag`.
- `sys_rst_n` pulsed low with `cnt`=2 in `PRESS_FILT` → outputs at defaults immediately; after reset release, a held press needs a full 4 new ticks.
- With `KEY_RELEASE_FLAG_EN`: press accepted, then `key_in`=1 held 4 ticks → one `rel_flag` pulse, `key_state`=1; without the macro the port is absent (compile check).
